// File: rtl/line_length_window_acc.sv
// Line-length window accumulator: sums |x[n]-x[n-1]| over a fixed window of
// signed samples and presents a saturated dividend/divisor pair, held under a
// valid/ready handshake, to a downstream signed divider.
module line_length_window_acc #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned WIN_LEN    = 256,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_drop,
  output logic [DATA_WIDTH-1:0] dividend_out,
  output logic [DATA_WIDTH-1:0] divisor_out,
  output logic                  sat_out,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  // Largest positive value of a signed DATA_WIDTH operand.
  localparam logic [DATA_WIDTH-1:0] MAX_POS   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0]  MAX_POS_A = ACC_WIDTH'(MAX_POS);
  localparam logic [CNT_WIDTH-1:0]  LAST_CNT  = CNT_WIDTH'(WIN_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] DIVISOR   = DATA_WIDTH'(WIN_LEN - 1);

  logic [0:0]            state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  prime_q, prime_d;
  logic [DATA_WIDTH-1:0] dividend_q, dividend_d;
  logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
  logic                  sat_q, sat_d;
  logic                  valid_q, valid_d;

  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] abs_diff;
  logic [ACC_WIDTH-1:0]  sum;
  logic                  sum_sat;

  // Sign-extended difference cannot wrap; its magnitude fits in DATA_WIDTH bits.
  always_comb begin
    diff     = {sample_in[DATA_WIDTH-1], sample_in} - {prev_q[DATA_WIDTH-1], prev_q};
    abs_diff = diff[DATA_WIDTH] ? DATA_WIDTH'(~diff + (DATA_WIDTH+1)'(1))
                                : diff[DATA_WIDTH-1:0];
    sum      = acc_q + ACC_WIDTH'(abs_diff);
    sum_sat  = (sum > MAX_POS_A);
  end

  // Samples arriving while a pair is pending are discarded; clear suppresses the report.
  always_comb begin
    sample_drop = sample_valid && (state_q == ST_HOLD) && !clear;
  end

  // Next-state logic: priming, accumulation, window completion and handshake.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    prime_d    = prime_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    sat_d      = sat_q;
    valid_d    = valid_q;
    if (clear) begin
      state_d    = ST_ACCUM;
      acc_d      = '0;
      cnt_d      = '0;
      prime_d    = 1'b1;
      valid_d    = 1'b0;
      dividend_d = '0;
      divisor_d  = '0;
      sat_d      = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (sample_valid) begin
            prev_d = sample_in;
            if (prime_q) begin
              prime_d = 1'b0;
              cnt_d   = CNT_WIDTH'(1);
            end else if (cnt_q == LAST_CNT) begin
              dividend_d = sum_sat ? MAX_POS : sum[DATA_WIDTH-1:0];
              sat_d      = sum_sat;
              divisor_d  = DIVISOR;
              valid_d    = 1'b1;
              state_d    = ST_HOLD;
              acc_d      = '0;
              cnt_d      = '0;
              prime_d    = 1'b1;
            end else begin
              acc_d = sum;
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        ST_HOLD: begin
          if (valid_q && out_ready) begin
            valid_d = 1'b0;
            state_d = ST_ACCUM;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      prev_q     <= '0;
      prime_q    <= 1'b1;
      dividend_q <= '0;
      divisor_q  <= '0;
      sat_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      prime_q    <= prime_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      sat_q      <= sat_d;
      valid_q    <= valid_d;
    end
  end

  assign dividend_out = dividend_q;
  assign divisor_out  = divisor_q;
  assign sat_out      = sat_q;
  assign out_valid    = valid_q;

endmodule

// File: tb/tb_line_length_window_acc.sv
// Directed bench for line_length_window_acc with WIN_LEN=8: expected pairs are
// computed from the driven samples, queued, and compared when out_valid rises.
module tb_line_length_window_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_drop;
  logic [15:0] dividend_out;
  logic [15:0] divisor_out;
  logic        sat_out;
  logic        out_valid;
  logic        out_ready = 1'b0;

  typedef struct packed {
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        sat;
  } pair_t;

  pair_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  line_length_window_acc #(
    .DATA_WIDTH(16),
    .WIN_LEN   (8),
    .CNT_WIDTH (16),
    .ACC_WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_drop (sample_drop),
    .dividend_out(dividend_out),
    .divisor_out (divisor_out),
    .sat_out     (sat_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input at the falling edge, return #1 after the rising edge.
  task automatic drive(input logic [15:0] s, input logic v);
    @(negedge clk);
    sample_in    = s;
    sample_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Reference line length for one window, clamped to 0x7FFF.
  task automatic feed_window(input logic [15:0] s [8]);
    int    acc;
    int    d;
    pair_t p;
    acc = 0;
    for (int i = 1; i < 8; i++) begin
      d = int'($signed(s[i])) - int'($signed(s[i-1]));
      acc += (d < 0) ? -d : d;
    end
    p.dividend = (acc > 32767) ? 16'h7FFF : acc[15:0];
    p.sat      = (acc > 32767);
    p.divisor  = 16'd7;
    exp_q.push_back(p);
    for (int i = 0; i < 8; i++) begin
      drive(s[i], 1'b1);
      if (i == 6) check("no_early_valid", {31'd0, out_valid}, 32'd0);
    end
  endtask

  // Output must be valid the cycle after the final sample.
  task automatic check_pair(input string tag);
    pair_t p;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      p = exp_q.pop_front();
      check({tag, "_dividend"}, {16'd0, dividend_out}, {16'd0, p.dividend});
      check({tag, "_divisor"}, {16'd0, divisor_out}, {16'd0, p.divisor});
      check({tag, "_sat"}, {31'd0, sat_out}, {31'd0, p.sat});
    end
  endtask

  task automatic release_pair(input string tag);
    @(negedge clk);
    sample_valid = 1'b0;
    out_ready    = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_released"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [15:0] w [8];

  initial begin
    // Reset state
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_dividend", {16'd0, dividend_out}, 32'd0);
    check("rst_divisor", {16'd0, divisor_out}, 32'd0);
    check("rst_sat", {31'd0, sat_out}, 32'd0);
    check("rst_drop", {31'd0, sample_drop}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Constant input
    w = '{16'h0123, 16'h0123, 16'h0123, 16'h0123, 16'h0123, 16'h0123, 16'h0123, 16'h0123};
    feed_window(w);
    check_pair("const");
    release_pair("const");

    // Ramp
    w = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    feed_window(w);
    check_pair("ramp");
    release_pair("ramp");

    // Negative swing
    w = '{16'd1000, 16'hFC18, 16'd1000, 16'hFC18, 16'd1000, 16'hFC18, 16'd1000, 16'hFC18};
    feed_window(w);
    check_pair("swing");
    check("swing_value", {16'd0, dividend_out}, 32'h36B0);
    release_pair("swing");

    // Saturation
    w = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
    feed_window(w);
    check_pair("sat");
    release_pair("sat");

    // Backpressure: pair held, samples dropped
    w = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    feed_window(w);
    check_pair("bp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      sample_in    = 16'(k * 77 + 300);
      sample_valid = 1'b1;
      out_ready    = 1'b0;
      #1;
      check("bp_drop", {31'd0, sample_drop}, 32'd1);
      @(posedge clk);
      #1;
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_dividend", {16'd0, dividend_out}, 32'd7);
    end
    // Handshake cycle: the sample presented here is still dropped
    @(negedge clk);
    sample_in = 16'd5000;
    out_ready = 1'b1;
    #1;
    check("bp_hs_drop", {31'd0, sample_drop}, 32'd1);
    @(posedge clk);
    #1;
    check("bp_hs_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    sample_valid = 1'b0;
    out_ready    = 1'b0;
    #1;
    check("bp_idle_drop", {31'd0, sample_drop}, 32'd0);
    w = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd8, 16'd10, 16'd12, 16'd14};
    feed_window(w);
    check_pair("bp_next");
    release_pair("bp_next");

    // Abort after 4 samples
    drive(16'd0, 1'b1);
    drive(16'd1000, 1'b1);
    drive(16'd0, 1'b1);
    drive(16'd1000, 1'b1);
    @(negedge clk);
    clear        = 1'b1;
    sample_in    = 16'd9999;
    sample_valid = 1'b1;
    #1;
    check("clr_drop", {31'd0, sample_drop}, 32'd0);
    @(posedge clk);
    #1;
    check("clr_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    clear        = 1'b0;
    sample_valid = 1'b0;
    w = '{16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17};
    feed_window(w);
    check_pair("clr_ramp");
    // Clear during HOLD drops the pending pair and zeroes outputs
    @(negedge clk);
    sample_valid = 1'b0;
    clear        = 1'b1;
    @(posedge clk);
    #1;
    check("clr_hold_valid", {31'd0, out_valid}, 32'd0);
    check("clr_hold_dividend", {16'd0, dividend_out}, 32'd0);
    check("clr_hold_divisor", {16'd0, divisor_out}, 32'd0);
    @(negedge clk);
    clear = 1'b0;

    // Asynchronous reset mid-HOLD
    w = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
    feed_window(w);
    check_pair("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_dividend", {16'd0, dividend_out}, 32'd0);
    check("arst_divisor", {16'd0, divisor_out}, 32'd0);
    check("arst_sat", {31'd0, sat_out}, 32'd0);
    @(negedge clk);
    sample_valid = 1'b0;
    rst_n        = 1'b1;

    // Reset mid-window loses the partial data
    drive(16'd0, 1'b1);
    drive(16'd3000, 1'b1);
    drive(16'd0, 1'b1);
    @(negedge clk);
    sample_valid = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    w = '{16'd20, 16'd22, 16'd20, 16'd22, 16'd20, 16'd22, 16'd20, 16'd22};
    feed_window(w);
    check_pair("post_rst");
    release_pair("post_rst");

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_length_window_acc.md
Name: line_length_window_acc

Overview:
- Upstream feeder for the signed 16-bit divider in the EEG feature path.
- Accumulates the line-length feature, sum of |x[n]-x[n-1]|, over a fixed window of EEG samples.
- At the end of each window, presents a registered dividend/divisor pair: saturated sum and number of differences.
- The divider produces the mean line length from this pair; a valid/ready handshake holds the pair until it is consumed.

Parameters:
- DATA_WIDTH, 16: sample, dividend and divisor width (must match the divider's input_width).
- WIN_LEN, 256: samples per window; legal range 2..32768.
- CNT_WIDTH, 16: sample counter width; must satisfy 2^CNT_WIDTH > WIN_LEN.
- ACC_WIDTH, 32: internal accumulator width; must not overflow for WIN_LEN differences of up to 2^DATA_WIDTH-1.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- clear, input, 1: synchronous window abort/restart.
- sample_in, input, DATA_WIDTH: signed two's-complement EEG sample.
- sample_valid, input, 1: sample_in is valid this cycle.
- sample_drop, output, 1: one-cycle pulse; a valid sample was discarded.
- dividend_out, output, DATA_WIDTH: saturated line-length sum; always non-negative.
- divisor_out, output, DATA_WIDTH: number of differences, WIN_LEN-1.
- sat_out, output, 1: dividend_out was clamped.
- out_valid, output, 1: dividend_out, divisor_out and sat_out are valid.
- out_ready, input, 1: downstream accepts the pair.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - State ACCUM; accumulator 0; counter 0; prev sample 0; prime flag 1.
  - dividend_out 0, divisor_out 0, sat_out 0, out_valid 0, sample_drop 0.
- States: ACCUM, HOLD.
- ACCUM, on sample_valid:
  - If the prime flag is set: store sample_in as prev, clear the prime flag, counter <= 1, no accumulation.
  - Otherwise: compute diff = sample_in - prev in DATA_WIDTH+1 signed bits (no wrap), take its absolute value (an unsigned DATA_WIDTH-bit value, max 2^DATA_WIDTH-1), and add it to the accumulator. Then prev <= sample_in and counter <= counter+1.
- Window completion: when the accepted sample is the WIN_LEN-th (counter == WIN_LEN-1 before the edge), the same edge:
  - Registers dividend_out = min(acc + |diff|, 2^(DATA_WIDTH-1)-1) and sat_out = 1 if clamped.
  - Registers divisor_out = WIN_LEN-1.
  - Sets out_valid = 1 and moves to HOLD.
  - Clears the accumulator and counter, and sets the prime flag.
- Latency: out_valid is high in the cycle immediately after the edge that accepts the final sample.
- The dividend is clamped to 0x7FFF (for DATA_WIDTH 16) so the downstream signed divider never sees a negative operand. The divisor is always positive.
- HOLD:
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - A sample_valid in HOLD is discarded and sample_drop pulses high for that cycle; no state is updated.
  - When out_valid && out_ready at an edge: out_valid <= 0 and the state returns to ACCUM.
  - A sample arriving in the handshake cycle itself is still dropped.
- Windows do not overlap. Each new window re-primes from its first sample; no difference is taken across a window boundary.
- clear (synchronous, priority over every other event except rst_n):
  - Next state ACCUM; accumulator, counter and out_valid cleared; prime flag set.
  - dividend_out, divisor_out and sat_out are forced to 0.
  - The sample presented in the same cycle is neither accumulated nor reported as dropped.
- Reset mid-window or mid-HOLD: all partial data is lost and the pending pair is lost; no output after reset until a full new window is collected.
- sample_drop is 0 whenever sample_valid is 0 or the state is ACCUM.
- Counter never exceeds WIN_LEN-1; there is no wrap.

Test Plan:
- Constant input: WIN_LEN=8, eight samples of 0x0123 -> out_valid the cycle after the 8th sample; dividend_out 0, divisor_out 7, sat_out 0.
- Ramp: WIN_LEN=8, samples 0..7, one per cycle -> dividend_out 7, divisor_out 7; with the divider downstream, quotient 1, remainder 0.
- Negative swing: WIN_LEN=8, samples alternating +1000/-1000 -> seven differences of 2000, dividend_out 14000 (0x36B0), sat_out 0.
- Saturation: WIN_LEN=8, samples alternating 32767/-32768 -> each |diff| is 65535; dividend_out 0x7FFF, sat_out 1, divisor_out 7.
- Backpressure: after a completed window, hold out_ready=0 for 5 cycles with sample_valid=1 -> outputs stable, sample_drop high on all 5 cycles. Then out_ready=1 -> out_valid falls next cycle, and the next window primes on the first sample after return to ACCUM.
- Abort: assert clear after 4 of 8 samples, then feed ramp 10..17 -> dividend_out 7. Separately, pulse rst_n low mid-HOLD -> all outputs 0 immediately (asynchronous).
